run_sequencer: RTL and testbench

//  Top-level program sequencer for the single-issue core. Owns the program counter and run state,

---
 rtl/run_sequencer.sv | 136 +++++++++++++
 tb/tb_run_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Program sequencer: owns PC and run state, qualifies architectural writes via ExecEn.
// Latency: Start -> first ExecEn next cycle; loads hold the PC for LOAD_WAIT extra cycles.
// No backpressure; Start is ignored while running. Optional PERF_CNT_EN builds InstrCnt/TakenCnt.
module run_sequencer #(
    parameter int PC_W      = 10,
    parameter int LOAD_WAIT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             Zero,
    input  logic             MemtoReg,
    input  logic             Halt,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             ExecEn,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstrCnt,
    output logic [CNT_W-1:0] TakenCnt
);

    localparam int WC_W = (LOAD_WAIT > 0) ? $clog2(LOAD_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LWAIT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc, pc_nxt;
    logic [WC_W-1:0]  wcnt, wcnt_nxt;
    logic [CNT_W-1:0] cyc_cnt;
    logic             exec_en;
    logic             clr_cnt;
    logic             busy;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            pc    <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wcnt_nxt  = wcnt;
        exec_en   = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    pc_nxt    = StartAddr;
                    clr_cnt   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                exec_en = 1'b1;
                // Halt outranks control flow; a load only stalls when nothing redirects.
                if (Halt) begin
                    state_nxt = S_DONE;
                end else if (Jump || (Branch && Zero)) begin
                    pc_nxt = Target;
                end else if (MemtoReg && (LOAD_WAIT > 0)) begin
                    exec_en   = 1'b0;
                    wcnt_nxt  = WC_W'(LOAD_WAIT);
                    state_nxt = S_LWAIT;
                end else begin
                    pc_nxt = pc + 1'b1;
                end
            end
            S_LWAIT: begin
                wcnt_nxt = wcnt - 1'b1;
                if (wcnt == WC_W'(1)) begin
                    exec_en   = 1'b1;
                    pc_nxt    = pc + 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN) || (state == S_LWAIT);

    always_ff @(posedge Clk) begin
        if (Reset || clr_cnt) begin
            cyc_cnt <= '0;
        end else if (busy && !(&cyc_cnt)) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic             taken;

    assign taken = (state == S_RUN) && !Halt && (Jump || (Branch && Zero));

    always_ff @(posedge Clk) begin
        if (Reset || clr_cnt) begin
            instr_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            if (exec_en && !(&instr_cnt)) instr_cnt <= instr_cnt + 1'b1;
            if (taken && !(&taken_cnt))   taken_cnt <= taken_cnt + 1'b1;
        end
    end

    assign InstrCnt = instr_cnt;
    assign TakenCnt = taken_cnt;
`else
    assign InstrCnt = '0;
    assign TakenCnt = '0;
`endif

    assign ProgCtr  = pc;
    assign ExecEn   = exec_en;
    assign Done     = (state == S_DONE);
    assign CycleCnt = cyc_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed scenarios then random instruction streams,
// compared every cycle against an instruction-level reference model.
module tb_run_sequencer;

    localparam int PC_W  = 10;
    localparam int LW    = 2;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset, Start, Branch, Jump, Zero, MemtoReg, Halt;
    logic [PC_W-1:0]  StartAddr, Target;
    logic [PC_W-1:0]  ProgCtr;
    logic             ExecEn, Done;
    logic [CNT_W-1:0] CycleCnt, InstrCnt, TakenCnt;

    run_sequencer #(.PC_W(PC_W), .LOAD_WAIT(LW), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Branch(Branch), .Jump(Jump), .Zero(Zero), .MemtoReg(MemtoReg),
        .Halt(Halt), .Target(Target), .ProgCtr(ProgCtr), .ExecEn(ExecEn),
        .Done(Done), .CycleCnt(CycleCnt), .InstrCnt(InstrCnt), .TakenCnt(TakenCnt)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the machine is either running an instruction stream or not;
    // m_age counts cycles already spent on the current (load) instruction.
    bit              m_known = 1'b0;
    bit              m_run, m_done;
    logic [PC_W-1:0] m_pc;
    int              m_age, m_cyc, m_instr, m_taken;

    // current random instruction, held while a load is in progress
    bit              c_br, c_jp, c_z, c_mr, c_h;
    logic [PC_W-1:0] c_tg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic bit model_exec(input bit br, jp, z, mr, h);
        if (!m_run)                return 1'b0;
        if (h || jp || (br && z))  return 1'b1;
        if (mr)                    return (m_age == LW);
        return 1'b1;
    endfunction

    task automatic cyc(input string tag, input bit rst, input bit st, input logic [PC_W-1:0] sa,
                       input bit br, input bit jp, input bit z, input bit mr, input bit h,
                       input logic [PC_W-1:0] tg);
        bit e;
        Reset = rst; Start = st; StartAddr = sa; Branch = br; Jump = jp;
        Zero = z; MemtoReg = mr; Halt = h; Target = tg;
        @(negedge Clk);
        e = model_exec(br, jp, z, mr, h);
        if (m_known) begin
            check({tag, " pc"},    32'(ProgCtr),  32'(m_pc));
            check({tag, " exec"},  32'(ExecEn),   32'(e));
            check({tag, " done"},  32'(Done),     32'(m_done));
            check({tag, " cyc"},   32'(CycleCnt), 32'(m_cyc));
            check({tag, " instr"}, 32'(InstrCnt), PERF ? 32'(m_instr) : 32'd0);
            check({tag, " taken"}, 32'(TakenCnt), PERF ? 32'(m_taken) : 32'd0);
        end
        @(posedge Clk);
        if (rst) begin
            m_known = 1'b1; m_run = 1'b0; m_done = 1'b0; m_pc = '0;
            m_age = 0; m_cyc = 0; m_instr = 0; m_taken = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1'b1; m_done = 1'b0; m_pc = sa;
                m_age = 0; m_cyc = 0; m_instr = 0; m_taken = 0;
            end
        end else begin
            m_cyc = sat(m_cyc);
            if (e) m_instr = sat(m_instr);
            if (h) begin
                m_run = 1'b0; m_done = 1'b1;
            end else if (jp || (br && z)) begin
                m_pc = tg; m_taken = sat(m_taken);
            end else if (mr && m_age < LW) begin
                m_age++;
            end else begin
                m_age = 0; m_pc = m_pc + 1'b1;
            end
        end
        #1;
    endtask

    task automatic plain(input string tag);
        cyc(tag, 0, 0, '0, 0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; StartAddr = '0; Branch = 1'b0; Jump = 1'b0;
        Zero = 1'b0; MemtoReg = 1'b0; Halt = 1'b0; Target = '0;
        @(posedge Clk); #1;

        cyc("rst0", 1, 0, '0, 0, 0, 0, 0, 0, '0);
        cyc("rst1", 1, 0, '0, 0, 0, 0, 0, 0, '0);
        plain("idle");

        // straight-line run from 0x010
        cyc("start", 0, 1, 10'h010, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) plain("seq");
        cyc("beq_t",  0, 0, '0, 1, 0, 1, 0, 0, 10'h200);
        cyc("beq_nt", 0, 0, '0, 1, 0, 0, 0, 0, 10'h300);
        cyc("jmp_br", 0, 0, '0, 1, 1, 1, 0, 0, 10'h050);
        // load at 0x050: three cycles, single commit
        for (int i = 0; i <= LW; i++) cyc("load", 0, 0, '0, 0, 0, 0, 1, 0, '0);
        plain("post_ld");
        cyc("halt", 0, 0, '0, 0, 1, 0, 0, 1, 10'h123);
        plain("done0");
        plain("done1");
        // restart near the top of the address space to exercise wrap
        cyc("restart", 0, 1, 10'h3FE, 0, 0, 0, 0, 0, '0);
        plain("wrap0");
        plain("wrap1");
        cyc("st_mid", 0, 1, 10'h0AA, 0, 0, 0, 0, 0, '0);
        plain("after_st");
        // reset in the second wait cycle of a load
        cyc("ld_a", 0, 0, '0, 0, 0, 0, 1, 0, '0);
        cyc("ld_b", 0, 0, '0, 0, 0, 0, 1, 0, '0);
        cyc("ld_rst", 1, 0, '0, 0, 0, 0, 1, 0, '0);
        plain("post_rst");

        // random instruction streams
        for (int n = 0; n < 3000; n++) begin
            bit rst, st;
            logic [PC_W-1:0] sa;
            int r;
            rst = ($urandom_range(0, 299) == 0);
            sa  = PC_W'($urandom);
            if (!m_run) begin
                st = ($urandom_range(0, 3) == 0);
                c_br = 0; c_jp = 0; c_z = 0; c_mr = 0; c_h = 0; c_tg = '0;
            end else begin
                st = ($urandom_range(0, 9) == 0);
                if (m_age == 0) begin
                    r = $urandom_range(0, 99);
                    c_tg = PC_W'($urandom);
                    c_z  = $urandom_range(0, 1) == 1;
                    c_h  = (r < 3);
                    c_jp = (r >= 3 && r < 13) || (r < 3 && c_z);
                    c_br = (r >= 13 && r < 38);
                    c_mr = (r >= 38 && r < 55) || ($urandom_range(0, 9) == 0);
                end
            end
            cyc("rnd", rst, st, sa, c_br, c_jp, c_z, c_mr, c_h, c_tg);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
